execute: RTL and testbench
==========================

EXECUTE -- requirements
Module: execute

Interface
REQ-001 Parameter DWIDTH, default 32, data/operand width.
REQ-002 Parameter IMM_WIDTH, default 16, immediate width.
REQ-003 Parameter PC_WIDTH, default 32, program-counter width.
REQ-004 One clock, es_clk; reset es_rst is asynchronous and active-low.
REQ-005 es_clk  input  1  rising-edge clock.
REQ-006 es_rst  input  1  asynchronous active-low reset.
REQ-007 es_i_ce  input  1  stage enable / valid-in.
REQ-008 es_i_alu_src  input  1  0: operand B = rt data; 1: operand B = extended immediate.
REQ-009 es_i_branch  input  1  instruction is a conditional branch.
REQ-010 es_i_pc  input  PC_WIDTH  PC of the instruction.
REQ-011 es_i_imm  input  IMM_WIDTH  raw immediate.
REQ-012 es_i_alu_op  input  OPCODE_WIDTH(6)  opcode class.
REQ-013 es_i_alu_funct  input  FUNCT_WIDTH(6)  function code.
REQ-014 es_i_data_rs, es_i_data_rt  input  DWIDTH  register operands.
REQ-015 es_o_alu_value  output  DWIDTH  registered ALU result.
REQ-016 es_o_alu_pc  output  PC_WIDTH  registered branch target.
REQ-017 es_o_opcode, es_o_funct  output  6 each  registered copies of es_i_alu_op, es_i_alu_funct.
REQ-018 es_o_zero  output  1  registered (ALU result == 0).
REQ-019 es_o_ce  output  1  registered es_i_ce (valid-out).
REQ-020 es_o_change_pc  output  1  registered branch-taken flag.

Function
REQ-021 All outputs SHALL be registered; latency exactly one es_clk rising edge from inputs.
REQ-022 On an edge with es_i_ce=1, all outputs SHALL update; with es_i_ce=0, es_o_ce SHALL become 0, es_o_change_pc SHALL become 0, and all other outputs SHALL hold.
REQ-023 Operand A = es_i_data_rs; operand B = es_i_alu_src ? ext(imm) : es_i_data_rt, except branches always use A=rs, B=rt.
REQ-024 ext(imm) SHALL be sign-extension to DWIDTH, except ANDI/ORI/XORI zero-extend.
REQ-025 RTYPE funct: ADD A+B, SUB A-B, AND, OR, XOR, NOR, SLT (signed, result 1/0), SLTU (unsigned), SLL/SRL/SRA B shifted by A[4:0]; all arithmetic modulo 2^DWIDTH, no overflow trap.
REQ-026 I-type opcodes: ADDI/LW/SW -> A+ext(imm); ANDI, ORI, XORI -> logic op; SLTI signed compare; LUI -> imm<<16.
REQ-027 BRANCH opcode: es_o_alu_value = rs - rt; funct BEQ taken when rs==rt, funct BNE taken when rs!=rt.
REQ-028 es_o_alu_pc SHALL equal es_i_pc + 4 + (signext(imm) << 2), truncated to PC_WIDTH, computed every enabled cycle.
REQ-029 es_o_change_pc SHALL be 1 only when es_i_ce=1, es_i_branch=1, opcode is BRANCH and the condition is true.
REQ-030 Unrecognised opcode/funct: es_o_alu_value=0, es_o_change_pc=0.
REQ-031 es_o_zero SHALL reflect the same-cycle computed result registered with it.

Reset
REQ-032 es_rst=0 SHALL immediately clear every output to 0, regardless of clock or es_i_ce.
REQ-033 Reset released mid-stream: first enabled edge after release SHALL produce normal results; no stale data.

Structure
REQ-034 OPCODE_WIDTH, FUNCT_WIDTH, opcode codes (RTYPE=000000, BRANCH=000100, ADDI=001000, SLTI=001010, ANDI=001100, ORI=001101, XORI=001110, LUI=001111, LW=100011, SW=101011) and funct codes (ADD=100000, SUB=100010, AND=100100, OR=100101, XOR=100110, NOR=100111, SLT=101010, SLTU=101011, SLL=000000, SRL=000010, SRA=000011, BEQ=000100, BNE=000101) SHALL live in the shared definitions package.
REQ-035 Combinational ALU SHALL be one sub-module, alu; execute wraps operand muxing, branch logic and output registers.

Verification
REQ-036 Reset held 2 cycles -> all outputs 0; release -> still 0 until es_i_ce=1.
REQ-037 ce=1, RTYPE ADD, rs=5, rt=4, alu_src=0 -> next edge alu_value=9, zero=0, change_pc=0, ce=1, opcode/funct echoed.
REQ-038 RTYPE SUB, rs=5, rt=4 -> alu_value=1; rs=rt=4 -> alu_value=0, zero=1.
REQ-039 BRANCH/BEQ, branch=1, alu_src=1, pc=10, imm=10, rs=rt=5 -> alu_value=0, zero=1, alu_pc=54, change_pc=1; rt=6 -> change_pc=0.
REQ-040 ADDI rs=5, imm=16'hFFFF, alu_src=1 -> alu_value=4; ANDI same imm -> alu_value=5.
REQ-041 Drop es_i_ce to 0 after a taken branch -> ce=0, change_pc=0, alu_value held; assert es_rst=0 between edges -> outputs 0 immediately.

Source files
------------

// File: rtl/execute_pkg.sv
// execute_pkg: opcode/funct encodings shared by the execute stage and its ALU
package execute_pkg;
    localparam int OPCODE_WIDTH = 6;
    localparam int FUNCT_WIDTH  = 6;
    typedef logic [OPCODE_WIDTH-1:0] opcode_t;
    typedef logic [FUNCT_WIDTH-1:0]  funct_t;
    localparam opcode_t OP_RTYPE  = 6'b000000;
    localparam opcode_t OP_BRANCH = 6'b000100;
    localparam opcode_t OP_ADDI   = 6'b001000;
    localparam opcode_t OP_SLTI   = 6'b001010;
    localparam opcode_t OP_ANDI   = 6'b001100;
    localparam opcode_t OP_ORI    = 6'b001101;
    localparam opcode_t OP_XORI   = 6'b001110;
    localparam opcode_t OP_LUI    = 6'b001111;
    localparam opcode_t OP_LW     = 6'b100011;
    localparam opcode_t OP_SW     = 6'b101011;
    localparam funct_t F_ADD  = 6'b100000;
    localparam funct_t F_SUB  = 6'b100010;
    localparam funct_t F_AND  = 6'b100100;
    localparam funct_t F_OR   = 6'b100101;
    localparam funct_t F_XOR  = 6'b100110;
    localparam funct_t F_NOR  = 6'b100111;
    localparam funct_t F_SLT  = 6'b101010;
    localparam funct_t F_SLTU = 6'b101011;
    localparam funct_t F_SLL  = 6'b000000;
    localparam funct_t F_SRL  = 6'b000010;
    localparam funct_t F_SRA  = 6'b000011;
    localparam funct_t F_BEQ  = 6'b000100;
    localparam funct_t F_BNE  = 6'b000101;
endpackage

// File: rtl/execute_alu.sv
// alu: combinational ALU; unknown opcode/funct combinations yield zero
module alu
    import execute_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [OPCODE_WIDTH-1:0] op,
    input  logic [FUNCT_WIDTH-1:0]  funct,
    input  logic [DWIDTH-1:0]       a,
    input  logic [DWIDTH-1:0]       b,
    output logic [DWIDTH-1:0]       result
);
    always_comb begin
        result = '0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   result = a + b;
                    F_SUB:   result = a - b;
                    F_AND:   result = a & b;
                    F_OR:    result = a | b;
                    F_XOR:   result = a ^ b;
                    F_NOR:   result = ~(a | b);
                    F_SLT:   result = DWIDTH'($signed(a) < $signed(b));
                    F_SLTU:  result = DWIDTH'(a < b);
                    F_SLL:   result = b << a[4:0];
                    F_SRL:   result = b >> a[4:0];
                    F_SRA:   result = DWIDTH'($signed(b) >>> a[4:0]);
                    default: result = '0;
                endcase
            end
            OP_BRANCH:             result = (funct == F_BEQ || funct == F_BNE) ? a - b : '0;
            OP_ADDI, OP_LW, OP_SW: result = a + b;
            OP_ANDI:               result = a & b;
            OP_ORI:                result = a | b;
            OP_XORI:               result = a ^ b;
            OP_SLTI:               result = DWIDTH'($signed(a) < $signed(b));
            OP_LUI:                result = b << 16;
            default:               result = '0;
        endcase
    end
endmodule

// File: rtl/execute.sv
// execute: operand select, branch resolution and the registered execute-stage outputs
module execute
    import execute_pkg::*;
#(
    parameter int DWIDTH    = 32,
    parameter int IMM_WIDTH = 16,
    parameter int PC_WIDTH  = 32
) (
    input  logic                    es_clk,
    input  logic                    es_rst,
    input  logic                    es_i_ce,
    input  logic                    es_i_alu_src,
    input  logic                    es_i_branch,
    input  logic [PC_WIDTH-1:0]     es_i_pc,
    input  logic [IMM_WIDTH-1:0]    es_i_imm,
    input  logic [OPCODE_WIDTH-1:0] es_i_alu_op,
    input  logic [FUNCT_WIDTH-1:0]  es_i_alu_funct,
    input  logic [DWIDTH-1:0]       es_i_data_rs,
    input  logic [DWIDTH-1:0]       es_i_data_rt,
    output logic [DWIDTH-1:0]       es_o_alu_value,
    output logic [PC_WIDTH-1:0]     es_o_alu_pc,
    output logic [OPCODE_WIDTH-1:0] es_o_opcode,
    output logic [FUNCT_WIDTH-1:0]  es_o_funct,
    output logic                    es_o_zero,
    output logic                    es_o_ce,
    output logic                    es_o_change_pc
);
    logic [DWIDTH-1:0]   sext, zext, op_b, result;
    logic [PC_WIDTH-1:0] pc_off, pc_target;
    logic                is_branch, zext_op, eq, taken;
    assign is_branch = es_i_alu_op == OP_BRANCH;
    assign zext_op   = es_i_alu_op inside {OP_ANDI, OP_ORI, OP_XORI, OP_LUI};
    assign sext      = {{(DWIDTH-IMM_WIDTH){es_i_imm[IMM_WIDTH-1]}}, es_i_imm};
    assign zext      = {{(DWIDTH-IMM_WIDTH){1'b0}}, es_i_imm};
    // branches compare registers, so the immediate never reaches the ALU for them
    assign op_b      = (es_i_alu_src && !is_branch) ? (zext_op ? zext : sext) : es_i_data_rt;
    assign eq        = es_i_data_rs == es_i_data_rt;
    assign taken     = es_i_ce && es_i_branch && is_branch &&
                       (es_i_alu_funct == F_BEQ ? eq : es_i_alu_funct == F_BNE ? !eq : 1'b0);
    assign pc_off    = {{(PC_WIDTH-IMM_WIDTH){es_i_imm[IMM_WIDTH-1]}}, es_i_imm};
    assign pc_target = es_i_pc + PC_WIDTH'(4) + (pc_off << 2);
    alu #(.DWIDTH(DWIDTH)) u_alu (
        .op    (es_i_alu_op),
        .funct (es_i_alu_funct),
        .a     (es_i_data_rs),
        .b     (op_b),
        .result(result)
    );
    always_ff @(posedge es_clk or negedge es_rst) begin
        if (!es_rst) begin
            es_o_alu_value <= '0;
            es_o_alu_pc    <= '0;
            es_o_opcode    <= '0;
            es_o_funct     <= '0;
            es_o_zero      <= 1'b0;
            es_o_ce        <= 1'b0;
            es_o_change_pc <= 1'b0;
        end else begin
            es_o_ce        <= es_i_ce;
            es_o_change_pc <= taken;
            if (es_i_ce) begin
                es_o_alu_value <= result;
                es_o_alu_pc    <= pc_target;
                es_o_opcode    <= es_i_alu_op;
                es_o_funct     <= es_i_alu_funct;
                es_o_zero      <= result == '0;
            end
        end
    end
endmodule

// File: tb/tb_execute.sv
// tb_execute: directed and random checks of execute against a spec-level reference model
module tb_execute;
    import execute_pkg::*;
    logic        es_clk = 1'b0, es_rst = 1'b0;
    logic        es_i_ce = 1'b0, es_i_alu_src = 1'b0, es_i_branch = 1'b0;
    logic [31:0] es_i_pc = '0, es_i_data_rs = '0, es_i_data_rt = '0;
    logic [15:0] es_i_imm = '0;
    logic [5:0]  es_i_alu_op = '0, es_i_alu_funct = '0;
    logic [31:0] es_o_alu_value, es_o_alu_pc;
    logic [5:0]  es_o_opcode, es_o_funct;
    logic        es_o_zero, es_o_ce, es_o_change_pc;
    logic [31:0] m_val, m_pc;
    logic [5:0]  m_op, m_fn;
    logic        m_zero, m_ce, m_chg;
    int          n_chk = 0, n_pass = 0;

    execute dut (
        .es_clk(es_clk), .es_rst(es_rst), .es_i_ce(es_i_ce), .es_i_alu_src(es_i_alu_src),
        .es_i_branch(es_i_branch), .es_i_pc(es_i_pc), .es_i_imm(es_i_imm),
        .es_i_alu_op(es_i_alu_op), .es_i_alu_funct(es_i_alu_funct),
        .es_i_data_rs(es_i_data_rs), .es_i_data_rt(es_i_data_rt),
        .es_o_alu_value(es_o_alu_value), .es_o_alu_pc(es_o_alu_pc), .es_o_opcode(es_o_opcode),
        .es_o_funct(es_o_funct), .es_o_zero(es_o_zero), .es_o_ce(es_o_ce),
        .es_o_change_pc(es_o_change_pc)
    );

    always #5 es_clk = ~es_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_alu(input logic [5:0] op, input logic [5:0] fn,
                                            input logic [31:0] rs, input logic [31:0] rt,
                                            input logic [15:0] imm, input logic src);
        logic [31:0] se, ze, b;
        se = {{16{imm[15]}}, imm};
        ze = {16'h0, imm};
        b  = src ? se : rt;
        case (op)
            OP_RTYPE: case (fn)
                F_ADD:   return rs + b;
                F_SUB:   return rs - b;
                F_AND:   return rs & b;
                F_OR:    return rs | b;
                F_XOR:   return rs ^ b;
                F_NOR:   return ~(rs | b);
                F_SLT:   return ($signed(rs) < $signed(b)) ? 32'd1 : 32'd0;
                F_SLTU:  return (rs < b) ? 32'd1 : 32'd0;
                F_SLL:   return b << rs[4:0];
                F_SRL:   return b >> rs[4:0];
                F_SRA:   return $signed(b) >>> rs[4:0];
                default: return 32'd0;
            endcase
            OP_BRANCH:             return rs - rt;
            OP_ADDI, OP_LW, OP_SW: return rs + se;
            OP_ANDI:               return rs & ze;
            OP_ORI:                return rs | ze;
            OP_XORI:               return rs ^ ze;
            OP_SLTI:               return ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
            OP_LUI:                return {imm, 16'h0};
            default:               return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        {m_val, m_pc, m_op, m_fn, m_zero, m_ce, m_chg} = '0;
    endtask

    task automatic model_edge();
        m_ce  = es_i_ce;
        m_chg = es_i_ce && es_i_branch && es_i_alu_op == OP_BRANCH &&
                ((es_i_alu_funct == F_BEQ && es_i_data_rs == es_i_data_rt) ||
                 (es_i_alu_funct == F_BNE && es_i_data_rs != es_i_data_rt));
        if (es_i_ce) begin
            m_val  = ref_alu(es_i_alu_op, es_i_alu_funct, es_i_data_rs, es_i_data_rt, es_i_imm, es_i_alu_src);
            m_pc   = es_i_pc + 32'd4 + {{14{es_i_imm[15]}}, es_i_imm, 2'b00};
            m_op   = es_i_alu_op;
            m_fn   = es_i_alu_funct;
            m_zero = m_val == 32'd0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".value"},  es_o_alu_value, m_val);
        check({tag, ".pc"},     es_o_alu_pc, m_pc);
        check({tag, ".opcode"}, es_o_opcode, m_op);
        check({tag, ".funct"},  es_o_funct, m_fn);
        check({tag, ".zero"},   es_o_zero, m_zero);
        check({tag, ".ce"},     es_o_ce, m_ce);
        check({tag, ".chg"},    es_o_change_pc, m_chg);
    endtask

    task automatic drive(input logic ce, input logic src, input logic br, input logic [31:0] pc,
                         input logic [15:0] imm, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt);
        es_i_ce = ce; es_i_alu_src = src; es_i_branch = br; es_i_pc = pc; es_i_imm = imm;
        es_i_alu_op = op; es_i_alu_funct = fn; es_i_data_rs = rs; es_i_data_rt = rt;
    endtask

    task automatic tick(input string tag);
        @(posedge es_clk);
        if (es_rst) model_edge();
        #1;
        check_all(tag);
    endtask

    logic [5:0] ops [11] = '{OP_RTYPE, OP_BRANCH, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI,
                             OP_XORI, OP_LUI, OP_LW, OP_SW, 6'b111111};
    logic [5:0] fns [12] = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU,
                             F_SLL, F_SRL, F_SRA, 6'b111110};

    initial begin
        model_reset();
        tick("rst0");
        tick("rst1");
        es_rst = 1'b1;
        tick("idle");
        drive(1, 0, 0, 32'h100, 16'h0, OP_RTYPE, F_ADD, 5, 4);
        tick("add");
        check("add9", es_o_alu_value, 32'd9);
        drive(1, 0, 0, 32'h104, 16'h0, OP_RTYPE, F_SUB, 5, 4);
        tick("sub");
        check("sub1", es_o_alu_value, 32'd1);
        drive(1, 0, 0, 32'h108, 16'h0, OP_RTYPE, F_SUB, 4, 4);
        tick("sub0");
        check("sub0z", es_o_zero, 1'b1);
        drive(1, 1, 1, 32'd10, 16'd10, OP_BRANCH, F_BEQ, 5, 5);
        tick("beq");
        check("beq_pc", es_o_alu_pc, 32'd54);
        check("beq_tk", es_o_change_pc, 1'b1);
        drive(0, 1, 1, 32'd10, 16'd10, OP_BRANCH, F_BEQ, 5, 5);
        tick("hold");
        check("hold_chg", es_o_change_pc, 1'b0);
        drive(1, 1, 1, 32'd10, 16'd10, OP_BRANCH, F_BEQ, 5, 6);
        tick("beq_nt");
        check("beq_nt_chg", es_o_change_pc, 1'b0);
        drive(1, 1, 0, 32'h200, 16'hFFFF, OP_ADDI, F_ADD, 5, 0);
        tick("addi");
        check("addi4", es_o_alu_value, 32'd4);
        drive(1, 1, 0, 32'h204, 16'hFFFF, OP_ANDI, F_ADD, 5, 0);
        tick("andi");
        check("andi5", es_o_alu_value, 32'd5);
        drive(1, 0, 1, 32'h300, 16'hFFFE, OP_BRANCH, F_BNE, 7, 3);
        tick("bne");
        check("bne_pc", es_o_alu_pc, 32'h2FC);
        #2 es_rst = 1'b0;
        #1 model_reset();
        check_all("async");
        es_rst = 1'b1;
        drive(1, 0, 0, 32'h400, 16'h0, OP_RTYPE, F_XOR, 32'hF0F0, 32'h0FF0);
        tick("post_rst");
        for (int i = 0; i < 400; i++) begin
            logic [5:0]  op, fn;
            logic [31:0] rs, rt;
            op = ops[$urandom_range(10)];
            fn = op == OP_BRANCH ? ($urandom_range(1) ? F_BEQ : F_BNE) : fns[$urandom_range(11)];
            rs = $urandom_range(3) == 0 ? 32'($urandom_range(40)) : $urandom;
            rt = $urandom_range(3) == 0 ? rs : $urandom;
            drive($urandom_range(99) < 85,
                  (op == OP_RTYPE || op == OP_BRANCH || op == 6'b111111) ? 1'($urandom_range(1)) : 1'b1,
                  op == OP_BRANCH && $urandom_range(99) < 80,
                  $urandom, 16'($urandom), op, fn, rs, rt);
            if ($urandom_range(99) < 3) begin
                #1 es_rst = 1'b0;
                #1 model_reset();
                check_all("rnd_rst");
                es_rst = 1'b1;
            end
            tick("rnd");
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
